// File: rtl/mc_ctl.sv
// mc_ctl: multi-cycle main control FSM for the MIPS datapath.
// Decodes the opcode, sequences fetch/decode/execute/memory/writeback,
// drives ALUOp toward alu_ctl plus every mux select and write strobe,
// waits on a memory ready handshake and counts retired instructions.
module mc_ctl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [5:0]       Op,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCond,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             MemtoReg,
  output logic             IRWrite,
  output logic [1:0]       PCSource,
  output logic [1:0]       ALUOp,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic             RegWrite,
  output logic             RegDst,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  typedef enum logic [3:0] {
    FETCH   = 4'd0,
    DECODE  = 4'd1,
    MEMADR  = 4'd2,
    MEMRD   = 4'd3,
    MEMWB   = 4'd4,
    MEMWR   = 4'd5,
    EXEC    = 4'd6,
    RWB     = 4'd7,
    BEQ     = 4'd8,
    JUMP    = 4'd9,
    ADDIEX  = 4'd10,
    ADDIWB  = 4'd11,
    ILLEGAL = 4'd15
  } state_t;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;

  state_t cur_state;
  state_t nxt_state;
  logic   retire;
  logic   illegal_q;

  assign state   = cur_state;
  assign illegal = illegal_q;

  // An instruction retires on the edge that leaves its final state;
  // a store only finishes once memory accepts the write.
  assign retire = (cur_state == MEMWB) || (cur_state == RWB) ||
                  (cur_state == BEQ)   || (cur_state == JUMP) ||
                  (cur_state == ADDIWB) ||
                  ((cur_state == MEMWR) && mem_ready);

  // State register; reset wins even in the middle of an instruction.
  always_ff @(posedge clk) begin
    if (!rst_n) cur_state <= FETCH;
    else        cur_state <= nxt_state;
  end

  // Sticky trap flag, set on entry to ILLEGAL and cleared only by reset.
  always_ff @(posedge clk) begin
    if (!rst_n)                     illegal_q <= 1'b0;
    else if (nxt_state == ILLEGAL)  illegal_q <= 1'b1;
  end

  // Retired-instruction counter, wraps naturally at 2^CNT_W.
  always_ff @(posedge clk) begin
    if (!rst_n)      instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end

  // Next-state and state-decoded outputs; write strobes masked during reset.
  always_comb begin
    nxt_state   = cur_state;
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    case (cur_state)
      FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        // PC+4 and the IR load only commit when the fetch data is valid.
        IRWrite = mem_ready;
        PCWrite = mem_ready;
        if (mem_ready) nxt_state = DECODE;
      end
      DECODE: begin
        ALUSrcB = 2'b11;
        case (Op)
          OP_LW, OP_SW: nxt_state = MEMADR;
          OP_R:         nxt_state = EXEC;
          OP_BEQ:       nxt_state = BEQ;
          OP_J:         nxt_state = JUMP;
          OP_ADDI:      nxt_state = ADDIEX;
          default:      nxt_state = ILLEGAL;
        endcase
      end
      MEMADR: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        nxt_state = (Op == OP_LW) ? MEMRD : MEMWR;
      end
      MEMRD: begin
        MemRead = 1'b1;
        IorD    = 1'b1;
        if (mem_ready) nxt_state = MEMWB;
      end
      MEMWB: begin
        RegWrite  = 1'b1;
        MemtoReg  = 1'b1;
        nxt_state = FETCH;
      end
      MEMWR: begin
        MemWrite = 1'b1;
        IorD     = 1'b1;
        if (mem_ready) nxt_state = FETCH;
      end
      EXEC: begin
        ALUSrcA   = 1'b1;
        ALUOp     = 2'b10;
        nxt_state = RWB;
      end
      RWB: begin
        RegWrite  = 1'b1;
        RegDst    = 1'b1;
        nxt_state = FETCH;
      end
      BEQ: begin
        ALUSrcA     = 1'b1;
        ALUOp       = 2'b01;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
        nxt_state   = FETCH;
      end
      JUMP: begin
        PCWrite   = 1'b1;
        PCSource  = 2'b10;
        nxt_state = FETCH;
      end
      ADDIEX: begin
        ALUSrcA   = 1'b1;
        ALUSrcB   = 2'b10;
        ALUOp     = 2'b11;
        nxt_state = ADDIWB;
      end
      ADDIWB: begin
        RegWrite  = 1'b1;
        nxt_state = FETCH;
      end
      ILLEGAL: nxt_state = ILLEGAL;
      default: nxt_state = FETCH;
    endcase
    if (!rst_n) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      IRWrite     = 1'b0;
      RegWrite    = 1'b0;
      MemWrite    = 1'b0;
    end
  end

endmodule

// File: tb/tb_mc_ctl.sv
// Bench for mc_ctl: per-cycle scoreboard of state, control word and instret.
module tb_mc_ctl;

  localparam int CNT_W = 4;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_J    = 6'b000010;
  localparam logic [5:0] OP_ADDI = 6'b001000;
  localparam logic [5:0] OP_BAD  = 6'b111111;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [5:0]       Op = 6'd0;
  logic             mem_ready = 1'b1;
  logic             PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg, IRWrite;
  logic [1:0]       PCSource, ALUOp, ALUSrcB;
  logic             ALUSrcA, RegWrite, RegDst, illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] instret;

  mc_ctl #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .Op(Op), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg),
    .IRWrite(IRWrite), .PCSource(PCSource), .ALUOp(ALUOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .RegWrite(RegWrite),
    .RegDst(RegDst), .illegal(illegal), .state(state), .instret(instret)
  );

  always #5 clk = ~clk;

  // Observed control word, packed in a fixed order for comparison.
  logic [16:0] ctl_obs;
  assign ctl_obs = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, MemtoReg,
                    IRWrite, PCSource, ALUOp, ALUSrcA, ALUSrcB, RegWrite,
                    RegDst, illegal};

  typedef struct {
    logic [5:0] op;
    logic       rdy;
    logic       rs;
    logic [3:0] st;
  } step_t;

  typedef struct {
    logic [3:0]       st;
    logic [16:0]      ctl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t             sb[$];
  logic [CNT_W-1:0] exp_cnt = '0;
  int               n_run = 0;
  int               n_fail = 0;

  // Reference control word for a state, straight from the state table.
  function automatic logic [16:0] exp_ctl(input logic [3:0] st, input logic rdy,
                                          input logic rs);
    logic pcw, pcwc, iord, mr, mw, m2r, irw, asa, rw, rd, ill;
    logic [1:0] pcs, aop, asb;
    pcw = 0; pcwc = 0; iord = 0; mr = 0; mw = 0; m2r = 0; irw = 0;
    asa = 0; rw = 0; rd = 0; ill = 0; pcs = 2'b00; aop = 2'b00; asb = 2'b00;
    case (st)
      4'd0:  begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      4'd1:  asb = 2'b11;
      4'd2:  begin asa = 1; asb = 2'b10; end
      4'd3:  begin mr = 1; iord = 1; end
      4'd4:  begin rw = 1; m2r = 1; end
      4'd5:  begin mw = 1; iord = 1; end
      4'd6:  begin asa = 1; aop = 2'b10; end
      4'd7:  begin rw = 1; rd = 1; end
      4'd8:  begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      4'd9:  begin pcw = 1; pcs = 2'b10; end
      4'd10: begin asa = 1; asb = 2'b10; aop = 2'b11; end
      4'd11: rw = 1;
      4'd15: ill = 1;
      default: ;
    endcase
    if (!rs) begin pcw = 0; pcwc = 0; irw = 0; rw = 0; mw = 0; end
    return {pcw, pcwc, iord, mr, mw, m2r, irw, pcs, aop, asa, asb, rw, rd, ill};
  endfunction

  // Drive one cycle of inputs at the falling edge and push what the DUT
  // should show this cycle; then advance the counter model past the next edge.
  task automatic drive(input logic [5:0] op, input logic rdy, input logic rs,
                       input logic [3:0] st);
    exp_t e;
    @(negedge clk);
    Op = op; mem_ready = rdy; rst_n = rs;
    e.st = st; e.ctl = exp_ctl(st, rdy, rs); e.cnt = exp_cnt;
    sb.push_back(e);
    if (!rs) exp_cnt = '0;
    else if (st == 4'd4 || st == 4'd7 || st == 4'd8 || st == 4'd9 ||
             st == 4'd11 || (st == 4'd5 && rdy)) exp_cnt = exp_cnt + 1'b1;
    #1;
  endtask

  task automatic test_reset();
    step_t s[$];
    exp_t  e;
    s.push_back('{OP_R, 1'b1, 1'b0, 4'd0});
    s.push_back('{OP_R, 1'b1, 1'b0, 4'd0});
    s.push_back('{OP_R, 1'b1, 1'b1, 4'd0});
    s.push_back('{OP_R, 1'b0, 1'b1, 4'd1});
    s.push_back('{OP_R, 1'b0, 1'b1, 4'd6});
    // Reset lands while RWB is asserting RegWrite: strobe must drop at once.
    s.push_back('{OP_R, 1'b1, 1'b0, 4'd7});
    s.push_back('{OP_R, 1'b1, 1'b0, 4'd0});
    foreach (s[i]) begin
      drive(s[i].op, s[i].rdy, s[i].rs, s[i].st);
      e = sb.pop_front();
      n_run++;
      if (state !== e.st || ctl_obs !== e.ctl || instret !== e.cnt) begin
        n_fail++;
        $display("FAIL reset[%0d]: got state=%0d ctl=%h instret=%0d, expected state=%0d ctl=%h instret=%0d",
                 i, state, ctl_obs, instret, e.st, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_lw();
    step_t s[$];
    exp_t  e;
    s.push_back('{OP_LW, 1'b1, 1'b1, 4'd0});
    s.push_back('{OP_LW, 1'b0, 1'b1, 4'd1});
    s.push_back('{OP_LW, 1'b0, 1'b1, 4'd2});
    s.push_back('{OP_LW, 1'b1, 1'b1, 4'd3});
    s.push_back('{OP_LW, 1'b0, 1'b1, 4'd4});
    s.push_back('{OP_R,  1'b1, 1'b1, 4'd0});
    foreach (s[i]) begin
      drive(s[i].op, s[i].rdy, s[i].rs, s[i].st);
      e = sb.pop_front();
      n_run++;
      if (state !== e.st || ctl_obs !== e.ctl || instret !== e.cnt) begin
        n_fail++;
        $display("FAIL lw[%0d]: got state=%0d ctl=%h instret=%0d, expected state=%0d ctl=%h instret=%0d",
                 i, state, ctl_obs, instret, e.st, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_rtype_addi();
    step_t s[$];
    exp_t  e;
    // FETCH for the R-type was already issued at the tail of the lw test.
    s.push_back('{OP_R,    1'b1, 1'b1, 4'd1});
    s.push_back('{OP_R,    1'b1, 1'b1, 4'd6});
    s.push_back('{OP_R,    1'b0, 1'b1, 4'd7});
    s.push_back('{OP_ADDI, 1'b1, 1'b1, 4'd0});
    s.push_back('{OP_ADDI, 1'b1, 1'b1, 4'd1});
    s.push_back('{OP_ADDI, 1'b0, 1'b1, 4'd10});
    s.push_back('{OP_ADDI, 1'b1, 1'b1, 4'd11});
    foreach (s[i]) begin
      drive(s[i].op, s[i].rdy, s[i].rs, s[i].st);
      e = sb.pop_front();
      n_run++;
      if (state !== e.st || ctl_obs !== e.ctl || instret !== e.cnt) begin
        n_fail++;
        $display("FAIL rtype_addi[%0d]: got state=%0d ctl=%h instret=%0d, expected state=%0d ctl=%h instret=%0d",
                 i, state, ctl_obs, instret, e.st, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_beq_j();
    step_t s[$];
    exp_t  e;
    s.push_back('{OP_BEQ, 1'b1, 1'b1, 4'd0});
    s.push_back('{OP_BEQ, 1'b1, 1'b1, 4'd1});
    s.push_back('{OP_BEQ, 1'b0, 1'b1, 4'd8});
    s.push_back('{OP_J,   1'b1, 1'b1, 4'd0});
    s.push_back('{OP_J,   1'b0, 1'b1, 4'd1});
    s.push_back('{OP_J,   1'b1, 1'b1, 4'd9});
    foreach (s[i]) begin
      drive(s[i].op, s[i].rdy, s[i].rs, s[i].st);
      e = sb.pop_front();
      n_run++;
      if (state !== e.st || ctl_obs !== e.ctl || instret !== e.cnt) begin
        n_fail++;
        $display("FAIL beq_j[%0d]: got state=%0d ctl=%h instret=%0d, expected state=%0d ctl=%h instret=%0d",
                 i, state, ctl_obs, instret, e.st, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_mem_stall();
    step_t s[$];
    exp_t  e;
    // Fetch stall: IRWrite/PCWrite held low until memory is ready.
    s.push_back('{OP_SW, 1'b0, 1'b1, 4'd0});
    s.push_back('{OP_SW, 1'b0, 1'b1, 4'd0});
    s.push_back('{OP_SW, 1'b1, 1'b1, 4'd0});
    s.push_back('{OP_SW, 1'b1, 1'b1, 4'd1});
    s.push_back('{OP_SW, 1'b1, 1'b1, 4'd2});
    for (int k = 0; k < 3; k++) s.push_back('{OP_SW, 1'b0, 1'b1, 4'd5});
    s.push_back('{OP_SW, 1'b1, 1'b1, 4'd5});
    // Load with a two-cycle MEMRD stall.
    s.push_back('{OP_LW, 1'b1, 1'b1, 4'd0});
    s.push_back('{OP_LW, 1'b1, 1'b1, 4'd1});
    s.push_back('{OP_LW, 1'b1, 1'b1, 4'd2});
    s.push_back('{OP_LW, 1'b0, 1'b1, 4'd3});
    s.push_back('{OP_LW, 1'b0, 1'b1, 4'd3});
    s.push_back('{OP_LW, 1'b1, 1'b1, 4'd3});
    s.push_back('{OP_LW, 1'b1, 1'b1, 4'd4});
    foreach (s[i]) begin
      drive(s[i].op, s[i].rdy, s[i].rs, s[i].st);
      e = sb.pop_front();
      n_run++;
      if (state !== e.st || ctl_obs !== e.ctl || instret !== e.cnt) begin
        n_fail++;
        $display("FAIL mem_stall[%0d]: got state=%0d ctl=%h instret=%0d, expected state=%0d ctl=%h instret=%0d",
                 i, state, ctl_obs, instret, e.st, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_back_to_back_wrap();
    step_t s[$];
    exp_t  e;
    for (int k = 0; k < 16; k++) begin
      s.push_back('{OP_J, 1'b1, 1'b1, 4'd0});
      s.push_back('{OP_J, 1'b1, 1'b1, 4'd1});
      s.push_back('{OP_J, 1'b1, 1'b1, 4'd9});
    end
    s.push_back('{OP_J, 1'b1, 1'b1, 4'd0});
    foreach (s[i]) begin
      drive(s[i].op, s[i].rdy, s[i].rs, s[i].st);
      e = sb.pop_front();
      n_run++;
      if (state !== e.st || ctl_obs !== e.ctl || instret !== e.cnt) begin
        n_fail++;
        $display("FAIL wrap[%0d]: got state=%0d ctl=%h instret=%0d, expected state=%0d ctl=%h instret=%0d",
                 i, state, ctl_obs, instret, e.st, e.ctl, e.cnt);
      end
    end
  endtask

  task automatic test_illegal();
    step_t s[$];
    exp_t  e;
    // FETCH for this instruction was issued at the tail of the wrap test.
    s.push_back('{OP_BAD, 1'b1, 1'b1, 4'd1});
    for (int k = 0; k < 20; k++)
      s.push_back('{OP_BAD, 1'($urandom_range(0, 1)), 1'b1, 4'd15});
    // Only reset leaves the trap; illegal clears on that edge.
    s.push_back('{OP_BAD, 1'b1, 1'b0, 4'd15});
    s.push_back('{OP_R,   1'b1, 1'b0, 4'd0});
    s.push_back('{OP_R,   1'b1, 1'b1, 4'd0});
    foreach (s[i]) begin
      drive(s[i].op, s[i].rdy, s[i].rs, s[i].st);
      e = sb.pop_front();
      n_run++;
      if (state !== e.st || ctl_obs !== e.ctl || instret !== e.cnt) begin
        n_fail++;
        $display("FAIL illegal[%0d]: got state=%0d ctl=%h instret=%0d, expected state=%0d ctl=%h instret=%0d",
                 i, state, ctl_obs, instret, e.st, e.ctl, e.cnt);
      end
    end
  endtask

  initial begin
    test_reset();
    test_lw();
    test_rtype_addi();
    test_beq_j();
    test_mem_stall();
    test_back_to_back_wrap();
    test_illegal();
    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

  // Safety net so the run always terminates.
  initial begin
    #100000;
    $display("FAIL timeout: simulation still running at %0t, expected completion", $time);
    $fatal(1);
  end

endmodule

// File: doc/mc_ctl.md
Name: mc_ctl

Overview:
- Multi-cycle main control FSM for the MIPS datapath; sits directly upstream of alu_ctl.
- Decodes the IR opcode and sequences fetch, decode, execute, memory and writeback.
- Produces ALUOp (consumed by alu_ctl), all datapath mux selects and all write strobes.
- Adds a memory ready handshake and a retired-instruction counter.

Parameters:
- CNT_W, 32, width of the retired-instruction counter.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst_n  in  1  synchronous reset, active-low.
- Op  in  6  IR[31:26] opcode.
- mem_ready  in  1  memory has completed the current read/write this cycle.
- PCWrite  out  1  unconditional PC load.
- PCWriteCond  out  1  PC load qualified by ALU zero (datapath ANDs with zero).
- IorD  out  1  memory address select: 0=PC, 1=ALUOut.
- MemRead  out  1  memory read request.
- MemWrite  out  1  memory write request.
- MemtoReg  out  1  register write-data select: 1=MDR, 0=ALUOut.
- IRWrite  out  1  instruction register load.
- PCSource  out  2  00=ALU result, 01=ALUOut, 10=jump target.
- ALUOp  out  2  to alu_ctl: 00 add, 01 sub, 10 use Funct, 11 add (immediate).
- ALUSrcA  out  1  0=PC, 1=A register.
- ALUSrcB  out  2  00=B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- RegWrite  out  1  register file write.
- RegDst  out  1  1=rd, 0=rt.
- illegal  out  1  unsupported opcode trapped.
- state  out  4  current state, for debug.
- instret  out  CNT_W  retired-instruction count.

Behaviour:
- Reset: the synchronous active-low reset is the decided interface; clock is clk, reset is rst_n. On any rising edge with rst_n=0: state←FETCH(0), instret←0, illegal←0. This takes priority mid-instruction.
- While rst_n=0, PCWrite, PCWriteCond, IRWrite, RegWrite and MemWrite are forced to 0.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, EXEC=6, RWB=7, BEQ=8, JUMP=9, ADDIEX=10, ADDIWB=11, ILLEGAL=15.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, j=000010, addi=001000.
- Outputs are decoded from state. Every signal not listed for a state is 0, including ALUOp=00.
  - FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=PCWrite=mem_ready (Mealy). Stay while mem_ready=0, else →DECODE.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next by Op: lw/sw→MEMADR, R→EXEC, beq→BEQ, j→JUMP, addi→ADDIEX, other→ILLEGAL.
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. lw→MEMRD, sw→MEMWR (Op still held in IR).
  - MEMRD: MemRead=1, IorD=1. Stay while mem_ready=0, else →MEMWB.
  - MEMWB: RegWrite=1, RegDst=0, MemtoReg=1. →FETCH.
  - MEMWR: MemWrite=1, IorD=1. Stay while mem_ready=0, else →FETCH.
  - EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=10. →RWB.
  - RWB: RegWrite=1, RegDst=1, MemtoReg=0. →FETCH.
  - BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCWriteCond=1, PCSource=01. →FETCH.
  - JUMP: PCWrite=1, PCSource=10. →FETCH.
  - ADDIEX: ALUSrcA=1, ALUSrcB=10, ALUOp=11. →ADDIWB.
  - ADDIWB: RegWrite=1, RegDst=0, MemtoReg=0. →FETCH.
  - ILLEGAL: illegal=1 (registered, set on entry), all strobes 0. Stays until reset.
- Latency in cycles with mem_ready always 1: lw 5, sw 4, R 4, addi 4, beq 3, j 3. Each cycle mem_ready=0 in FETCH/MEMRD/MEMWR adds 1.
- instret increments by 1 on the edge leaving MEMWB, RWB, BEQ, JUMP or ADDIWB, or leaving MEMWR with mem_ready=1. Wraps modulo 2^CNT_W. No increment on ILLEGAL entry.
- mem_ready is ignored in states that do not wait on it.

Test Plan:
- Reset: rst_n=0 for 2 edges from EXEC → state=0, instret=0, RegWrite=0 during reset; release → MemRead=1 in FETCH.
- lw, mem_ready=1: state sequence 0,1,2,3,4,0; MemtoReg=1 and RegWrite=1 only in state 4; instret 0→1.
- R-type (Op=0): ALUOp=10 in EXEC only, RegDst=1 in RWB. addi (Op=001000): ALUOp=11 in state 10, RegDst=0 in state 11.
- beq: PCWriteCond=1, ALUOp=01, PCSource=01 for exactly 1 cycle. j: PCWrite=1, PCSource=10 for 1 cycle.
- sw with mem_ready low 3 cycles in MEMWR: MemWrite held 4 cycles, no instret increment until mem_ready=1. FETCH stall: IRWrite=0 until mem_ready=1.
- Op=111111: DECODE→15, illegal=1, all strobes 0 for 20 cycles. CNT_W=4 with 16 j instructions: instret wraps 15→0.
